// File: rtl/mem_ctrl_arbiter.sv
// N-channel round-robin front end to the single main-memory controller port.
// One-entry request register toward memory; in-order read tracking FIFO routes responses back.
module mem_ctrl_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 26,
  parameter int BLOCK_W = 512,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ch_req_valid,
  input  logic [N_CH-1:0]           ch_req_type,
  input  logic [N_CH*ADDR_W-1:0]    ch_req_block_addr,
  input  logic [N_CH*BLOCK_W-1:0]   ch_req_block_data,
  output logic [N_CH-1:0]           ch_req_ready,
  output logic [N_CH-1:0]           ch_resp_valid,
  output logic [BLOCK_W-1:0]        ch_resp_block_data,
  input  logic [N_CH-1:0]           ch_flush,
  output logic                      mem_req_valid,
  output logic                      mem_req_type,
  output logic [ADDR_W-1:0]         mem_req_block_addr,
  output logic [BLOCK_W-1:0]        mem_req_block_data,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [BLOCK_W-1:0]        mem_resp_block_data,
  output logic                      busy,
  output logic                      err_unexpected_resp
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam logic [PTR_W:0] MAX_CNT = (PTR_W+1)'(MAX_OUT);

  // output register
  logic                oreg_vld_q, oreg_vld_d;
  logic                oreg_type_q, oreg_type_d;
  logic [ADDR_W-1:0]   oreg_addr_q, oreg_addr_d;
  logic [BLOCK_W-1:0]  oreg_data_q, oreg_data_d;
  logic [CH_W-1:0]     oreg_ch_q, oreg_ch_d;
  logic                oreg_drop_q, oreg_drop_d;

  // tracking FIFO
  logic [MAX_OUT-1:0][CH_W-1:0] fifo_ch_q, fifo_ch_d;
  logic [MAX_OUT-1:0]           fifo_drop_q, fifo_drop_d;
  logic [PTR_W:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [CH_W-1:0]     rr_q, rr_d;
  logic [N_CH-1:0]     resp_vld_q, resp_vld_d;
  logic [BLOCK_W-1:0]  resp_data_q, resp_data_d;
  logic                err_q, err_d;

  logic                drain, can_accept, push, pop, fifo_empty, read_ok, accept;
  logic                grant_found, pop_drop;
  logic [CH_W-1:0]     grant_idx, head_ch;
  logic [PTR_W:0]      cnt, cnt_nx;
  logic [N_CH-1:0]     elig;
  int                  idx;

  assign drain      = oreg_vld_q & mem_req_ready;
  assign can_accept = ~oreg_vld_q | drain;
  assign cnt        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (cnt == '0);
  assign push       = drain & ~oreg_type_q;
  assign pop        = mem_resp_valid & ~fifo_empty;
  assign cnt_nx     = cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign read_ok    = (cnt_nx < MAX_CNT);
  assign elig       = ch_req_valid & (ch_req_type | {N_CH{read_ok}});
  assign head_ch    = fifo_ch_q[rd_ptr_q[PTR_W-1:0]];
  // A flush landing on the pop cycle still kills the popped entry.
  assign pop_drop   = fifo_drop_q[rd_ptr_q[PTR_W-1:0]] | ch_flush[head_ch];

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_q) + k) % N_CH;
      if (!grant_found && elig[CH_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  assign accept       = grant_found & can_accept;
  assign ch_req_ready = accept ? (N_CH'(1) << grant_idx) : '0;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (grant_idx == CH_W'(N_CH-1)) ? '0 : grant_idx + CH_W'(1);
  end

  always_comb begin
    oreg_vld_d  = oreg_vld_q;
    oreg_type_d = oreg_type_q;
    oreg_addr_d = oreg_addr_q;
    oreg_data_d = oreg_data_q;
    oreg_ch_d   = oreg_ch_q;
    oreg_drop_d = oreg_drop_q;
    if (accept) begin
      // a fresh request is never dropped by a flush in its own accept cycle
      oreg_vld_d  = 1'b1;
      oreg_type_d = ch_req_type[grant_idx];
      oreg_addr_d = ch_req_block_addr[grant_idx*ADDR_W +: ADDR_W];
      oreg_data_d = ch_req_block_data[grant_idx*BLOCK_W +: BLOCK_W];
      oreg_ch_d   = grant_idx;
      oreg_drop_d = 1'b0;
    end else if (drain) begin
      oreg_vld_d  = 1'b0;
      oreg_drop_d = 1'b0;
    end else if (oreg_vld_q && ch_flush[oreg_ch_q]) begin
      oreg_drop_d = 1'b1;
    end
  end

  always_comb begin
    fifo_ch_d   = fifo_ch_q;
    fifo_drop_d = fifo_drop_q;
    for (int e = 0; e < MAX_OUT; e++)
      if (ch_flush[fifo_ch_q[e]]) fifo_drop_d[e] = 1'b1;
    if (push) begin
      fifo_ch_d[wr_ptr_q[PTR_W-1:0]]   = oreg_ch_q;
      fifo_drop_d[wr_ptr_q[PTR_W-1:0]] = oreg_drop_q | ch_flush[oreg_ch_q];
    end
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  end

  always_comb begin
    resp_vld_d  = '0;
    resp_data_d = resp_data_q;
    if (pop) resp_data_d = mem_resp_block_data;
    if (pop && !pop_drop) resp_vld_d = N_CH'(1) << head_ch;
    err_d = err_q | (mem_resp_valid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oreg_vld_q  <= 1'b0;
      oreg_type_q <= 1'b0;
      oreg_addr_q <= '0;
      oreg_data_q <= '0;
      oreg_ch_q   <= '0;
      oreg_drop_q <= 1'b0;
      fifo_ch_q   <= '0;
      fifo_drop_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rr_q        <= '0;
      resp_vld_q  <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      oreg_vld_q  <= oreg_vld_d;
      oreg_type_q <= oreg_type_d;
      oreg_addr_q <= oreg_addr_d;
      oreg_data_q <= oreg_data_d;
      oreg_ch_q   <= oreg_ch_d;
      oreg_drop_q <= oreg_drop_d;
      fifo_ch_q   <= fifo_ch_d;
      fifo_drop_q <= fifo_drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_q        <= rr_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_valid       = oreg_vld_q;
  assign mem_req_type        = oreg_type_q;
  assign mem_req_block_addr  = oreg_addr_q;
  assign mem_req_block_data  = oreg_data_q;
  assign ch_resp_valid       = resp_vld_q;
  assign ch_resp_block_data  = resp_data_q;
  assign busy                = oreg_vld_q | ~fifo_empty;
  assign err_unexpected_resp = err_q;

endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
Parametrised N-channel front end to the single main-memory controller port. It replaces the fixed pair of icache and dcache mem_ctrl interfaces that today leave the core separately. Requests are arbitrated round-robin into a one-entry output register. Outstanding reads are tracked in order so each response is routed back to its requesting channel, and a per-channel flush discards responses that belong to squashed work, such as a fetch redirect.

Parameters:
N_CH, 2, number of requesting channels (>=2); channel 0 is icache, channel 1 is dcache.
ADDR_W, 26, main-memory block address width.
BLOCK_W, 512, block data width.
MAX_OUT, 4, maximum outstanding reads; power of 2, >=2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_req_valid  in  N_CH  request valid, per channel
ch_req_type  in  N_CH  request type per channel; 0 = read, 1 = write
ch_req_block_addr  in  N_CH*ADDR_W  block address; channel i occupies slice [i*ADDR_W +: ADDR_W]
ch_req_block_data  in  N_CH*BLOCK_W  write data; channel i occupies slice [i*BLOCK_W +: BLOCK_W]
ch_req_ready  out  N_CH  one-hot accept for the granted channel
ch_resp_valid  out  N_CH  one-hot read response valid
ch_resp_block_data  out  BLOCK_W  read response data, shared by all channels
ch_flush  in  N_CH  drop all in-flight reads of the flagged channels
mem_req_valid  out  1  request to memory controller
mem_req_type  out  1  0 = read, 1 = write
mem_req_block_addr  out  ADDR_W  request block address
mem_req_block_data  out  BLOCK_W  request write data
mem_req_ready  in  1  memory controller accepts the request
mem_resp_valid  in  1  read response valid
mem_resp_block_data  in  BLOCK_W  read response data
busy  out  1  high when the output register is full or the tracking FIFO is non-empty
err_unexpected_resp  out  1  sticky; set by a response arriving with the FIFO empty

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all outputs go to 0;
  - round-robin pointer goes to 0;
  - output register empties;
  - tracking FIFO empties;
  - err_unexpected_resp clears.
- Reset mid-operation abandons in-flight work. Later mem_resp_valid pulses are not routed to any channel; they set err_unexpected_resp.
- Output register (OREG), one entry holding {type, addr, data, ch_id}:
  - it can accept a request when it is empty, or when it is draining this cycle (mem_req_valid & mem_req_ready);
  - mem_req_* is driven from OREG and stays stable while mem_req_valid=1 and mem_req_ready=0.
- Eligibility and arbitration:
  - channel i is eligible when ch_req_valid[i]=1, and, if it is a read, the tracking FIFO will not be full after this cycle's push and pop;
  - writes are never blocked by FIFO occupancy;
  - the grant goes to the first eligible channel at or after rr_ptr, searching upward modulo N_CH;
  - ch_req_ready[g]=1 only when OREG can accept; the handshake is combinational in the same cycle;
  - on a grant, rr_ptr becomes (g+1) mod N_CH; otherwise rr_ptr holds.
- Latency: handshake in cycle T gives mem_req_valid=1 in cycle T+1.
- Memory handshake: when mem_req_valid & mem_req_ready and the type is read, {ch_id, drop=0} is pushed to the FIFO. Writes push nothing and produce no response.
- Responses:
  - on mem_resp_valid, the FIFO head is popped;
  - if drop=0: ch_resp_valid[ch_id]=1 for exactly one cycle at T+1, with ch_resp_block_data registered from mem_resp_block_data;
  - if drop=1: nothing is asserted.
- Flush (ch_flush[i]=1 in cycle T):
  - sets drop on every FIFO entry with ch_id=i, including an entry being pushed in T;
  - if OREG holds a channel-i read, that read is still issued to memory and enters the FIFO with drop=1;
  - flush on the same cycle as a matching pop: the popped entry is dropped;
  - flush does not block new requests from channel i in the same cycle; those are not dropped.
- Simultaneous push and pop when the FIFO is full is legal; occupancy is unchanged.
- Pointers are log2(MAX_OUT) bits and wrap; full/empty are distinguished with an extra wrap bit.

Test Plan:
- ch0 read, addr 0x10, mem_req_ready=1 at T → mem_req_valid=1 at T+1 with addr 0x10, type 0; mem_resp_valid at T+5 with data 0xAA..AA → ch_resp_valid=2'b01 at T+6, data 0xAA..AA; busy=0 at T+7.
- ch0 and ch1 both requesting continuously, mem_req_ready=1 → grants 0,1,0,1; each ch_req_ready is one-hot; mem_req_block_addr alternates between the two channels' addresses.
- MAX_OUT=2, three ch1 reads with no responses → third ch_req_ready stays 0; a ch0 write in the same window is accepted and issued; after one mem_resp, the third read is accepted within 1 cycle.
- ch0 read then ch1 read outstanding, ch_flush[0] pulse, two responses 0x11.., 0x22.. → no ch_resp_valid for 0x11; ch_resp_valid=2'b10 with data 0x22..; FIFO empty afterwards.
- mem_req_ready=0 for 3 cycles with OREG full → mem_req_* constant, all ch_req_ready=0; on release, next request issues the following cycle.
- 2 reads outstanding, rst=1 for 1 cycle, then 2 mem_resp pulses → no ch_resp_valid; err_unexpected_resp=1 and stays 1 until the next rst.
